// File: rtl/mycounter_param_pkg.sv
// Shared constants and types for the parametrised up/down counter.
package mycounter_param_pkg;

  // Direction encoding of the dir input.
  localparam logic MYCNT_DIR_UP   = 1'b1;
  localparam logic MYCNT_DIR_DOWN = 1'b0;

  // The single action the counter performs in a cycle, highest priority first.
  typedef enum logic [1:0] {
    ACT_NONE  = 2'd0,
    ACT_CLEAR = 2'd1,
    ACT_LOAD  = 2'd2,
    ACT_STEP  = 2'd3
  } cnt_act_e;

  // Width of the prescaler counter; a one-bit counter is kept for PRESCALE=1.
  function automatic int presc_width(input int prescale);
    return (prescale > 1) ? $clog2(prescale) : 1;
  endfunction

endpackage

// File: rtl/mycounter_param_prescaler.sv
// Enable prescaler: emits one strobe for every PRESCALE cycles with en high.
module mycounter_prescaler
  import mycounter_param_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic CLK,
  input  logic RST,
  input  logic en,
  input  logic sclr,
  output logic strobe
);

  localparam int CW = presc_width(PRESCALE);
  localparam logic [CW-1:0] TOP = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_p0;
  logic          at_top;

  // With PRESCALE=1 TOP is 0 and the counter never leaves 0, so strobe follows en.
  assign at_top = (cnt_p0 == TOP);
  assign strobe = en & at_top & ~sclr;

  // Count enabled cycles; restart on reset, clear/load, or after the strobe.
  always_ff @(posedge CLK) begin
    if (RST || sclr) begin
      cnt_p0 <= '0;
    end else if (en) begin
      if (at_top) cnt_p0 <= '0;
      else        cnt_p0 <= cnt_p0 + CW'(1);
    end
  end

endmodule

// File: rtl/mycounter_param.sv
// Parametrised up/down counter with modulo or saturating limits, load/clear,
// enable prescaler, and wrap/overflow flags for chaining.
module mycounter_param
  import mycounter_param_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MAX      = 2**WIDTH - 1,
  parameter int PRESCALE = 1,
  parameter int SATURATE = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             en,
  input  logic             dir,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  // Loaded values above the top count are pinned to it.
  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    return (v > MAX_V) ? MAX_V : v;
  endfunction

  // True when a step in direction d from cnt would cross a limit.
  function automatic logic at_limit(input logic [WIDTH-1:0] cnt, input logic d);
    return (d == MYCNT_DIR_UP) ? (cnt == MAX_V) : (cnt == '0);
  endfunction

  // Next count for a step; limits wrap to the opposite end or hold, never rely on overflow.
  function automatic logic [WIDTH-1:0] step_val(input logic [WIDTH-1:0] cnt, input logic d);
    logic [WIDTH-1:0] nv;
    if (d == MYCNT_DIR_UP) begin
      if (cnt == MAX_V) nv = (SATURATE != 0) ? MAX_V : '0;
      else              nv = cnt + WIDTH'(1);
    end else begin
      if (cnt == '0)    nv = (SATURATE != 0) ? '0 : MAX_V;
      else              nv = cnt - WIDTH'(1);
    end
    return nv;
  endfunction

  logic     strobe_p0;
  logic     sclr_p0;
  cnt_act_e act_p0;

  // Clear and load both restart the prescaler so a partial count never leaks.
  assign sclr_p0 = clear | load;

  mycounter_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_presc (
    .CLK    (CLK),
    .RST    (RST),
    .en     (en),
    .sclr   (sclr_p0),
    .strobe (strobe_p0)
  );

  // Resolve the one action of this cycle: clear > load > step.
  always_comb begin
    act_p0 = ACT_NONE;
    if (clear)          act_p0 = ACT_CLEAR;
    else if (load)      act_p0 = ACT_LOAD;
    else if (strobe_p0) act_p0 = ACT_STEP;
  end

  // Count register with wrap pulse and sticky overflow.
  always_ff @(posedge CLK) begin
    if (RST) begin
      out  <= '0;
      wrap <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      case (act_p0)
        ACT_CLEAR: begin
          out  <= '0;
          wrap <= 1'b0;
          ovf  <= 1'b0;
        end
        ACT_LOAD: begin
          out  <= clamp_load(load_val);
          wrap <= 1'b0;
        end
        ACT_STEP: begin
          out  <= step_val(out, dir);
          wrap <= at_limit(out, dir);
          if (at_limit(out, dir)) ovf <= 1'b1;
        end
        default: begin
          wrap <= 1'b0;
        end
      endcase
    end
  end

  // Terminal count follows the current direction without waiting for a clock.
  assign tc = at_limit(out, dir);

endmodule

// File: tb/tb_mycounter_param.sv
// Self-checking bench: three counter configurations driven in lockstep,
// each compared against a behavioural model of the counting rules.
module tb_mycounter_param;

  localparam int NI = 3;
  // Instance 0: 4-bit defaults; 1: MAX=9 PRESCALE=3 wrapping; 2: MAX=9 saturating.
  localparam int P_MAX [NI] = '{15, 9, 9};
  localparam int P_PS  [NI] = '{1, 3, 1};
  localparam int P_SAT [NI] = '{0, 0, 1};

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       en = 1'b0, dir = 1'b1, clear = 1'b0, load = 1'b0;
  logic [3:0] load_val = '0;
  logic [3:0] q_out  [NI];
  logic       q_tc   [NI];
  logic       q_wrap [NI];
  logic       q_ovf  [NI];

  int m_cnt [NI];
  int m_pre [NI];
  bit m_wrap [NI];
  bit m_ovf  [NI];
  int total = 0;
  int bad = 0;

  always #5 CLK = ~CLK;

  mycounter_param u0 (
    .CLK(CLK), .RST(RST), .en(en), .dir(dir), .clear(clear), .load(load),
    .load_val(load_val), .out(q_out[0]), .tc(q_tc[0]), .wrap(q_wrap[0]), .ovf(q_ovf[0])
  );

  mycounter_param #(.WIDTH(4), .MAX(9), .PRESCALE(3), .SATURATE(0)) u1 (
    .CLK(CLK), .RST(RST), .en(en), .dir(dir), .clear(clear), .load(load),
    .load_val(load_val), .out(q_out[1]), .tc(q_tc[1]), .wrap(q_wrap[1]), .ovf(q_ovf[1])
  );

  mycounter_param #(.WIDTH(4), .MAX(9), .PRESCALE(1), .SATURATE(1)) u2 (
    .CLK(CLK), .RST(RST), .en(en), .dir(dir), .clear(clear), .load(load),
    .load_val(load_val), .out(q_out[2]), .tc(q_tc[2]), .wrap(q_wrap[2]), .ovf(q_ovf[2])
  );

  // Apply one cycle of inputs, advance the reference model at the edge, settle.
  task automatic cycle(input bit r, input bit e, input bit d, input bit c, input bit l, input int lv);
    RST = r; en = e; dir = d; clear = c; load = l; load_val = 4'(lv);
    @(posedge CLK);
    for (int k = 0; k < NI; k++) begin
      if (r || c) begin
        m_cnt[k] = 0; m_pre[k] = 0; m_wrap[k] = 0; m_ovf[k] = 0;
      end else if (l) begin
        m_cnt[k] = (lv > P_MAX[k]) ? P_MAX[k] : lv;
        m_pre[k] = 0; m_wrap[k] = 0;
      end else begin
        bit stp;
        stp = 0;
        m_wrap[k] = 0;
        if (e) begin
          m_pre[k] = m_pre[k] + 1;
          if (m_pre[k] == P_PS[k]) begin m_pre[k] = 0; stp = 1; end
        end
        if (stp && d) begin
          if (m_cnt[k] == P_MAX[k]) begin
            m_wrap[k] = 1; m_ovf[k] = 1;
            m_cnt[k] = (P_SAT[k] != 0) ? P_MAX[k] : 0;
          end else m_cnt[k] = m_cnt[k] + 1;
        end else if (stp) begin
          if (m_cnt[k] == 0) begin
            m_wrap[k] = 1; m_ovf[k] = 1;
            m_cnt[k] = (P_SAT[k] != 0) ? 0 : P_MAX[k];
          end else m_cnt[k] = m_cnt[k] - 1;
        end
      end
    end
    #1;
  endtask

  function automatic bit exp_tc(input int k);
    return dir ? (m_cnt[k] == P_MAX[k]) : (m_cnt[k] == 0);
  endfunction

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1, $urandom_range(0, 1), $urandom_range(0, 1), 0, 0, 0);
      for (int k = 0; k < NI; k++) begin
        total++;
        if (q_out[k] !== 4'd0) begin bad++; $display("FAIL reset_out inst%0d got=%0d exp=0", k, q_out[k]); end
        total++;
        if (q_wrap[k] !== 1'b0 || q_ovf[k] !== 1'b0) begin
          bad++; $display("FAIL reset_flags inst%0d got wrap=%0b ovf=%0b exp 0 0", k, q_wrap[k], q_ovf[k]);
        end
        total++;
        if (q_tc[k] !== exp_tc(k)) begin bad++; $display("FAIL reset_tc inst%0d got=%0b exp=%0b", k, q_tc[k], exp_tc(k)); end
      end
    end
  endtask

  task automatic test_count_up();
    for (int i = 0; i < 40; i++) begin
      cycle(0, 1, 1, 0, 0, 0);
      for (int k = 0; k < NI; k++) begin
        total++;
        if (q_out[k] !== 4'(m_cnt[k]) || q_wrap[k] !== m_wrap[k] || q_ovf[k] !== m_ovf[k] || q_tc[k] !== exp_tc(k)) begin
          bad++;
          $display("FAIL count_up inst%0d cyc%0d got out=%0d wrap=%0b ovf=%0b tc=%0b exp out=%0d wrap=%0b ovf=%0b tc=%0b",
                   k, i, q_out[k], q_wrap[k], q_ovf[k], q_tc[k], m_cnt[k], m_wrap[k], m_ovf[k], exp_tc(k));
        end
      end
    end
    // 40 steps from 0 on a 16-state counter lands on 8 with ovf set.
    total++;
    if (q_out[0] !== 4'd8 || q_ovf[0] !== 1'b1) begin
      bad++; $display("FAIL count_up_end got out=%0d ovf=%0b exp out=8 ovf=1", q_out[0], q_ovf[0]);
    end
  endtask

  task automatic test_down_and_sat();
    cycle(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 12; i++) begin
      cycle(0, 1, 0, 0, 0, 0);
      for (int k = 0; k < NI; k++) begin
        total++;
        if (q_out[k] !== 4'(m_cnt[k]) || q_wrap[k] !== m_wrap[k] || q_ovf[k] !== m_ovf[k] || q_tc[k] !== exp_tc(k)) begin
          bad++;
          $display("FAIL down inst%0d cyc%0d got out=%0d wrap=%0b ovf=%0b tc=%0b exp out=%0d wrap=%0b ovf=%0b tc=%0b",
                   k, i, q_out[k], q_wrap[k], q_ovf[k], q_tc[k], m_cnt[k], m_wrap[k], m_ovf[k], exp_tc(k));
        end
      end
    end
    cycle(0, 0, 1, 0, 1, 9);
    for (int i = 0; i < 6; i++) begin
      cycle(0, 1, 1, 0, 0, 0);
      for (int k = 0; k < NI; k++) begin
        total++;
        if (q_out[k] !== 4'(m_cnt[k]) || q_wrap[k] !== m_wrap[k] || q_ovf[k] !== m_ovf[k] || q_tc[k] !== exp_tc(k)) begin
          bad++;
          $display("FAIL sat_up inst%0d cyc%0d got out=%0d wrap=%0b ovf=%0b tc=%0b exp out=%0d wrap=%0b ovf=%0b tc=%0b",
                   k, i, q_out[k], q_wrap[k], q_ovf[k], q_tc[k], m_cnt[k], m_wrap[k], m_ovf[k], exp_tc(k));
        end
      end
      // Saturating instance holds at 9 and pulses wrap on every strobe.
      total++;
      if (q_out[2] !== 4'd9 || q_wrap[2] !== 1'b1) begin
        bad++; $display("FAIL sat_hold got out=%0d wrap=%0b exp out=9 wrap=1", q_out[2], q_wrap[2]);
      end
    end
  endtask

  task automatic test_prescale();
    cycle(0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 16; i++) begin
      bit e;
      e = !(i == 7 || i == 8);
      cycle(0, e, 1, 0, 0, 0);
      for (int k = 0; k < NI; k++) begin
        total++;
        if (q_out[k] !== 4'(m_cnt[k]) || q_wrap[k] !== m_wrap[k] || q_ovf[k] !== m_ovf[k] || q_tc[k] !== exp_tc(k)) begin
          bad++;
          $display("FAIL prescale inst%0d cyc%0d got out=%0d wrap=%0b ovf=%0b tc=%0b exp out=%0d wrap=%0b ovf=%0b tc=%0b",
                   k, i, q_out[k], q_wrap[k], q_ovf[k], q_tc[k], m_cnt[k], m_wrap[k], m_ovf[k], exp_tc(k));
        end
      end
    end
    // 14 enabled cycles at PRESCALE=3 give four increments.
    total++;
    if (q_out[1] !== 4'd4) begin bad++; $display("FAIL prescale_end got=%0d exp=4", q_out[1]); end
  endtask

  task automatic test_load_clear();
    cycle(0, 0, 1, 0, 1, 12);
    total++;
    if (q_out[0] !== 4'd12 || q_out[1] !== 4'd9 || q_out[2] !== 4'd9) begin
      bad++; $display("FAIL load_clamp got %0d %0d %0d exp 12 9 9", q_out[0], q_out[1], q_out[2]);
    end
    for (int i = 0; i < 8; i++) cycle(0, 1, 1, 0, 0, 0);
    cycle(0, 1, 1, 1, 1, 5);
    for (int k = 0; k < NI; k++) begin
      total++;
      if (q_out[k] !== 4'd0 || q_ovf[k] !== 1'b0 || q_wrap[k] !== 1'b0) begin
        bad++; $display("FAIL load_clear inst%0d got out=%0d ovf=%0b wrap=%0b exp 0 0 0", k, q_out[k], q_ovf[k], q_wrap[k]);
      end
    end
    cycle(0, 1, 1, 0, 1, 3);
    for (int k = 0; k < NI; k++) begin
      total++;
      if (q_out[k] !== 4'd3 || q_out[k] !== 4'(m_cnt[k])) begin
        bad++; $display("FAIL load_step inst%0d got=%0d exp=3", k, q_out[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    cycle(0, 0, 1, 0, 1, 7);
    cycle(0, 1, 1, 0, 0, 0);
    cycle(0, 1, 1, 0, 0, 0);
    cycle(1, 1, 1, 0, 0, 0);
    for (int k = 0; k < NI; k++) begin
      total++;
      if (q_out[k] !== 4'd0 || q_wrap[k] !== 1'b0 || q_ovf[k] !== 1'b0) begin
        bad++; $display("FAIL reset_mid inst%0d got out=%0d wrap=%0b ovf=%0b exp 0 0 0", k, q_out[k], q_wrap[k], q_ovf[k]);
      end
    end
    for (int i = 0; i < 7; i++) begin
      cycle(0, 1, 1, 0, 0, 0);
      for (int k = 0; k < NI; k++) begin
        total++;
        if (q_out[k] !== 4'(m_cnt[k]) || q_wrap[k] !== m_wrap[k] || q_ovf[k] !== m_ovf[k]) begin
          bad++;
          $display("FAIL after_reset inst%0d cyc%0d got out=%0d wrap=%0b ovf=%0b exp out=%0d wrap=%0b ovf=%0b",
                   k, i, q_out[k], q_wrap[k], q_ovf[k], m_cnt[k], m_wrap[k], m_ovf[k]);
        end
      end
      if (i == 1) begin
        total++;
        if (q_out[1] !== 4'd0) begin bad++; $display("FAIL presc_restart early got=%0d exp=0", q_out[1]); end
      end
      if (i == 2) begin
        total++;
        if (q_out[1] !== 4'd1) begin bad++; $display("FAIL presc_restart got=%0d exp=1", q_out[1]); end
      end
    end
  endtask

  task automatic test_dir_toggle();
    cycle(0, 0, 1, 0, 1, 5);
    for (int i = 0; i < 8; i++) begin
      bit d;
      d = (i % 2 == 0);
      dir = d;
      #1;
      for (int k = 0; k < NI; k++) begin
        total++;
        if (q_tc[k] !== exp_tc(k)) begin bad++; $display("FAIL tc_comb inst%0d got=%0b exp=%0b", k, q_tc[k], exp_tc(k)); end
      end
      cycle(0, 1, d, 0, 0, 0);
      total++;
      if (q_out[0] !== (d ? 4'd6 : 4'd5) || q_out[0] !== 4'(m_cnt[0])) begin
        bad++; $display("FAIL dir_toggle cyc%0d got=%0d exp=%0d", i, q_out[0], m_cnt[0]);
      end
    end
    cycle(0, 0, 1, 0, 1, 0);
    dir = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) begin
      total++;
      if (q_tc[k] !== 1'b1) begin bad++; $display("FAIL tc_zero_down inst%0d got=%0b exp=1", k, q_tc[k]); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 59) == 0), ($urandom_range(0, 9) < 7), $urandom_range(0, 1),
            ($urandom_range(0, 29) == 0), ($urandom_range(0, 9) == 0), $urandom_range(0, 15));
      for (int k = 0; k < NI; k++) begin
        total++;
        if (q_out[k] !== 4'(m_cnt[k]) || q_wrap[k] !== m_wrap[k] || q_ovf[k] !== m_ovf[k] || q_tc[k] !== exp_tc(k)) begin
          bad++;
          $display("FAIL random inst%0d cyc%0d got out=%0d wrap=%0b ovf=%0b tc=%0b exp out=%0d wrap=%0b ovf=%0b tc=%0b",
                   k, i, q_out[k], q_wrap[k], q_ovf[k], q_tc[k], m_cnt[k], m_wrap[k], m_ovf[k], exp_tc(k));
        end
      end
    end
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      m_cnt[k] = 0; m_pre[k] = 0; m_wrap[k] = 0; m_ovf[k] = 0;
    end
    test_reset();
    test_count_up();
    test_down_and_sat();
    test_prescale();
    test_load_clear();
    test_reset_mid();
    test_dir_toggle();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
